// File: rtl/pwm_nbit_pkg.sv
// pwm_nbit_pkg: shared constants, types and helpers for the multi-channel PWM peripheral.
//   pwm_max(width)      - top counter value MAX = 2^width - 2 (period is 2^width - 1 ticks)
//   pwm_width_ok(width) - legal counter/duty width range check (4..16)
//   pwm_ch_width(nch)   - width of the channel-index port, at least 1 bit
//   duty_word_t         - widest duty word the peripheral supports
package pwm_nbit_pkg;

    localparam int unsigned MinWidth = 4;
    localparam int unsigned MaxWidth = 16;

    typedef logic [MaxWidth-1:0] duty_word_t;

    function automatic duty_word_t pwm_max(input int unsigned width);
        return duty_word_t'((32'd1 << width) - 32'd2);
    endfunction

    function automatic bit pwm_width_ok(input int unsigned width);
        return (width >= MinWidth) && (width <= MaxWidth);
    endfunction

    function automatic int unsigned pwm_ch_width(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/pwm_nbit_channel.sv
// pwm_nbit_channel: one PWM output with a double-buffered duty register.
//   clk_i       clock
//   rst_i       synchronous reset, active high
//   wr_i        duty write for this channel (already decoded)
//   duty_i      new duty value, loaded into the pending register
//   boundary_i  period boundary; pending duty moves to active if valid
//   cnt_i       shared period counter
//   incl_eq_i   also treat cnt_i == active as high (center-aligned up-slope)
//   pwm_o       registered PWM output, reset to Invert
module pwm_nbit_channel #(
    parameter int unsigned Width  = 8,
    parameter logic        Invert = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [Width-1:0] duty_i,
    input  logic             boundary_i,
    input  logic [Width-1:0] cnt_i,
    input  logic             incl_eq_i,
    output logic             pwm_o
);

    logic [Width-1:0] pend_q, pend_d;
    logic [Width-1:0] act_q, act_d;
    logic             valid_q, valid_d;
    logic             pwm_q, pwm_d;
    logic             hit;

    always_comb begin
        pend_d  = pend_q;
        valid_d = valid_q;
        act_d   = act_q;
        // Transfer reads pend_q, so a write landing on the boundary stays pending
        // for the following boundary.
        if (boundary_i && valid_q) begin
            act_d   = pend_q;
            valid_d = 1'b0;
        end
        if (wr_i) begin
            pend_d  = duty_i;
            valid_d = 1'b1;
        end
        hit   = (cnt_i < act_q) || (incl_eq_i && (cnt_i == act_q));
        pwm_d = hit ^ Invert;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            act_q   <= '0;
            pwm_q   <= Invert;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            act_q   <= act_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_multi_nbit.sv
// pwm_multi_nbit: parametrised multi-channel PWM with one shared counter.
//   i_clk     processor clock
//   i_rst     synchronous reset, active high
//   i_wr      duty write strobe
//   i_ch      channel index for i_wr; indices >= G_NCHANNELS are ignored
//   i_duty    new duty value
//   o_pwm     registered PWM outputs (reset value G_INVERT)
//   o_period  one-clock pulse in the cycle after the period boundary
// Build option: define PWM_NBIT_CENTER_EN for center-aligned (up/down) counting;
// otherwise the counter is an edge-aligned sawtooth 0..MAX.
module pwm_multi_nbit
    import pwm_nbit_pkg::*;
#(
    parameter int unsigned           G_WIDTH     = 8,
    parameter int unsigned           G_NCHANNELS = 3,
    parameter int unsigned           G_PRESCALE  = 1,
    parameter logic [G_NCHANNELS-1:0] G_INVERT   = '0
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_wr,
    input  logic [pwm_ch_width(G_NCHANNELS)-1:0]    i_ch,
    input  logic [G_WIDTH-1:0]                      i_duty,
    output logic [G_NCHANNELS-1:0]                  o_pwm,
    output logic                                    o_period
);

    localparam int unsigned        ChW     = pwm_ch_width(G_NCHANNELS);
    localparam logic [15:0]        PreLast = 16'(G_PRESCALE - 1);
    localparam logic [G_WIDTH-1:0] CntMax  = G_WIDTH'(pwm_max(G_WIDTH));
    localparam logic [G_WIDTH-1:0] CntOne  = G_WIDTH'(1);

    if (!pwm_width_ok(G_WIDTH)) begin : g_bad_width
        $error("pwm_multi_nbit: G_WIDTH out of range 4..16");
    end

    logic [15:0]        pre_q, pre_d;
    logic [G_WIDTH-1:0] cnt_q, cnt_d;
    logic               period_q;
    logic               tick;
    logic               boundary;
    logic               incl_eq;

    assign tick  = (pre_q == PreLast);
    assign pre_d = tick ? 16'd0 : pre_q + 16'd1;

`ifdef PWM_NBIT_CENTER_EN
    logic down_q, down_d;

    // Sequence per period: 0(down, boundary), 1..MAX up, MAX-1..1 down, back to 0.
    // Endpoints are not repeated, so each period is 2*MAX ticks.
    always_comb begin
        cnt_d    = cnt_q;
        down_d   = down_q;
        boundary = 1'b0;
        if (tick) begin
            if (down_q) begin
                if (cnt_q == '0) begin
                    cnt_d    = CntOne;
                    down_d   = 1'b0;
                    boundary = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end else if (cnt_q == CntMax) begin
                cnt_d  = CntMax - CntOne;
                down_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
        // Up-slope covers 1..MAX and down-slope MAX-1..0; counting cnt == duty as high
        // on the up-slope gives exactly 2*duty high ticks, symmetric about cnt = 0.
        incl_eq = !down_q && (cnt_q != '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down_d;
        end
    end
`else
    always_comb begin
        cnt_d    = cnt_q;
        boundary = 1'b0;
        incl_eq  = 1'b0;
        if (tick) begin
            if (cnt_q == CntMax) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + CntOne;
            end
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pre_q    <= 16'd0;
            cnt_q    <= '0;
            period_q <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            period_q <= boundary;
        end
    end

    assign o_period = period_q;

    for (genvar c = 0; c < G_NCHANNELS; c++) begin : g_ch
        logic wr_sel;
        assign wr_sel = i_wr && (i_ch == ChW'(c));

        pwm_nbit_channel #(
            .Width  (G_WIDTH),
            .Invert (G_INVERT[c])
        ) u_channel (
            .clk_i      (i_clk),
            .rst_i      (i_rst),
            .wr_i       (wr_sel),
            .duty_i     (i_duty),
            .boundary_i (boundary),
            .cnt_i      (cnt_q),
            .incl_eq_i  (incl_eq),
            .pwm_o      (o_pwm[c])
        );
    end

endmodule

// File: tb/tb_pwm_multi_nbit.sv
// tb_pwm_multi_nbit: directed self-checking bench for pwm_multi_nbit.
// DUT A: G_WIDTH=8, 3 channels, prescale 1, invert 3'b100 (period 255 clocks).
// DUT B: G_WIDTH=4, 3 channels, prescale 4, invert 3'b100 (period 60 clocks).
module tb_pwm_multi_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, wr_a, per_a;
    logic [1:0] ch_a;
    logic [7:0] duty_a;
    logic [2:0] pwm_a;

    logic       rst_b, wr_b, per_b;
    logic [1:0] ch_b;
    logic [3:0] duty_b;
    logic [2:0] pwm_b;

    int checks = 0;
    int errors = 0;

    pwm_multi_nbit #(
        .G_WIDTH     (8),
        .G_NCHANNELS (3),
        .G_PRESCALE  (1),
        .G_INVERT    (3'b100)
    ) u_dut_a (
        .i_clk    (clk),
        .i_rst    (rst_a),
        .i_wr     (wr_a),
        .i_ch     (ch_a),
        .i_duty   (duty_a),
        .o_pwm    (pwm_a),
        .o_period (per_a)
    );

    pwm_multi_nbit #(
        .G_WIDTH     (4),
        .G_NCHANNELS (3),
        .G_PRESCALE  (4),
        .G_INVERT    (3'b100)
    ) u_dut_b (
        .i_clk    (clk),
        .i_rst    (rst_b),
        .i_wr     (wr_b),
        .i_ch     (ch_b),
        .i_duty   (duty_b),
        .o_pwm    (pwm_b),
        .o_period (per_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full DUT A period starting right after a boundary sample; optional writes
    // are presented before step j1 / j2 (0 disables).
    task automatic measure_a(input int j1, input logic [1:0] c1, input logic [7:0] d1,
                             input int j2, input logic [1:0] c2, input logic [7:0] d2,
                             output int h0, output int h1, output int h2,
                             output logic b64, output logic b65, output int per_at);
        h0 = 0; h1 = 0; h2 = 0; b64 = 1'b0; b65 = 1'b0; per_at = -1;
        for (int j = 1; j <= 255; j++) begin
            wr_a = 1'b0;
            if (j == j1) begin wr_a = 1'b1; ch_a = c1; duty_a = d1; end
            if (j == j2) begin wr_a = 1'b1; ch_a = c2; duty_a = d2; end
            step();
            if (pwm_a[0]) h0++;
            if (pwm_a[1]) h1++;
            if (pwm_a[2]) h2++;
            if (j == 64) b64 = pwm_a[0];
            if (j == 65) b65 = pwm_a[0];
            if (per_a && per_at < 0) per_at = j;
        end
        wr_a = 1'b0;
    endtask

    task automatic measure_b(output int h0, output int h2, output logic b20,
                             output logic b21, output int per_at);
        h0 = 0; h2 = 0; b20 = 1'b0; b21 = 1'b0; per_at = -1;
        for (int j = 1; j <= 60; j++) begin
            step();
            if (pwm_b[0]) h0++;
            if (pwm_b[2]) h2++;
            if (j == 20) b20 = pwm_b[0];
            if (j == 21) b21 = pwm_b[0];
            if (per_b && per_at < 0) per_at = j;
        end
    endtask

    task automatic test_reset();
        int first, second, npulse, pwm_bad;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) step();
        checks++;
        if (pwm_a !== 3'b100) begin
            errors++; $display("FAIL reset_pwm_a: got %b expected 100", pwm_a);
        end
        checks++;
        if (per_a !== 1'b0) begin
            errors++; $display("FAIL reset_period_a: got %b expected 0", per_a);
        end
        checks++;
        if (pwm_b !== 3'b100) begin
            errors++; $display("FAIL reset_pwm_b: got %b expected 100", pwm_b);
        end
        rst_a = 1'b0;
        first = -1; second = -1; npulse = 0; pwm_bad = 0;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (pwm_a !== 3'b100) pwm_bad++;
            if (per_a === 1'b1) begin
                npulse++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        checks++;
        if (first != 255) begin
            errors++; $display("FAIL idle_first_period: got %0d expected 255", first);
        end
        checks++;
        if (second != 510) begin
            errors++; $display("FAIL idle_second_period: got %0d expected 510", second);
        end
        checks++;
        if (npulse != 2) begin
            errors++; $display("FAIL idle_pulse_count: got %0d expected 2", npulse);
        end
        checks++;
        if (pwm_bad != 0) begin
            errors++; $display("FAIL idle_pwm_constant: got %0d deviations expected 0", pwm_bad);
        end
    endtask

    task automatic test_duty();
        int n, pwm_bad, h0, h1, h2, per_at;
        logic b64, b65;
        wr_a = 1'b1;
        ch_a = 2'd0; duty_a = 8'd64;  step();
        ch_a = 2'd1; duty_a = 8'd0;   step();
        ch_a = 2'd2; duty_a = 8'd255; step();
        wr_a = 1'b0;
        n = -1; pwm_bad = 0;
        for (int k = 1; k <= 300; k++) begin
            step();
            if (pwm_a !== 3'b100) pwm_bad++;
            if (per_a === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 242) begin
            errors++; $display("FAIL duty_wait_boundary: got %0d expected 242", n);
        end
        checks++;
        if (pwm_bad != 0) begin
            errors++; $display("FAIL duty_before_boundary: got %0d deviations expected 0", pwm_bad);
        end
        measure_a(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, h0, h1, h2, b64, b65, per_at);
        checks++;
        if (h0 != 64) begin
            errors++; $display("FAIL duty_ch0_high: got %0d expected 64", h0);
        end
        checks++;
        if (h1 != 0) begin
            errors++; $display("FAIL duty_ch1_high: got %0d expected 0", h1);
        end
        checks++;
        if (h2 != 0) begin
            errors++; $display("FAIL duty_ch2_inv_high: got %0d expected 0", h2);
        end
        checks++;
        if (b64 !== 1'b1 || b65 !== 1'b0) begin
            errors++; $display("FAIL duty_ch0_edge: got %b%b expected 10", b64, b65);
        end
        checks++;
        if (per_at != 255) begin
            errors++; $display("FAIL duty_period: got %0d expected 255", per_at);
        end
    endtask

    task automatic test_last_write_wins();
        int h0, h1, h2, per_at;
        logic b64, b65;
        measure_a(5, 2'd0, 8'd10, 9, 2'd0, 8'd200, h0, h1, h2, b64, b65, per_at);
        checks++;
        if (h0 != 64) begin
            errors++; $display("FAIL midwrite_current_period: got %0d expected 64", h0);
        end
        checks++;
        if (per_at != 255) begin
            errors++; $display("FAIL midwrite_period: got %0d expected 255", per_at);
        end
        measure_a(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, h0, h1, h2, b64, b65, per_at);
        checks++;
        if (h0 != 200) begin
            errors++; $display("FAIL midwrite_applied: got %0d expected 200", h0);
        end
    endtask

    task automatic test_boundary_write();
        int h0, h1, h2, per_at;
        logic b64, b65;
        measure_a(100, 2'd3, 8'd77, 255, 2'd1, 8'd128, h0, h1, h2, b64, b65, per_at);
        checks++;
        if (per_at != 255) begin
            errors++; $display("FAIL bwrite_on_boundary: got %0d expected 255", per_at);
        end
        measure_a(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, h0, h1, h2, b64, b65, per_at);
        checks++;
        if (h1 != 0) begin
            errors++; $display("FAIL bwrite_old_duty_kept: got %0d expected 0", h1);
        end
        checks++;
        if (h0 != 200) begin
            errors++; $display("FAIL bad_index_ch0: got %0d expected 200", h0);
        end
        checks++;
        if (h2 != 0) begin
            errors++; $display("FAIL bad_index_ch2: got %0d expected 0", h2);
        end
        measure_a(0, 2'd0, 8'd0, 0, 2'd0, 8'd0, h0, h1, h2, b64, b65, per_at);
        checks++;
        if (h1 != 128) begin
            errors++; $display("FAIL bwrite_applied_later: got %0d expected 128", h1);
        end
        checks++;
        if (h0 != 200 || h2 != 0) begin
            errors++; $display("FAIL bwrite_others: got %0d/%0d expected 200/0", h0, h2);
        end
    endtask

    task automatic test_prescale_reset();
        int n, h0, h2, per_at;
        logic b20, b21;
        rst_b = 1'b0;
        wr_b = 1'b1; ch_b = 2'd0; duty_b = 4'd5;
        step();
        wr_b = 1'b0;
        n = -1;
        for (int k = 2; k <= 200; k++) begin
            step();
            if (per_b === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 60) begin
            errors++; $display("FAIL pre_first_period: got %0d expected 60", n);
        end
        measure_b(h0, h2, b20, b21, per_at);
        checks++;
        if (h0 != 20) begin
            errors++; $display("FAIL pre_ch0_high: got %0d expected 20", h0);
        end
        checks++;
        if (b20 !== 1'b1 || b21 !== 1'b0) begin
            errors++; $display("FAIL pre_ch0_edge: got %b%b expected 10", b20, b21);
        end
        checks++;
        if (h2 != 60) begin
            errors++; $display("FAIL pre_ch2_inv_high: got %0d expected 60", h2);
        end
        checks++;
        if (per_at != 60) begin
            errors++; $display("FAIL pre_period_len: got %0d expected 60", per_at);
        end
        // Leave a write pending, then reset mid-period.
        for (int j = 1; j <= 10; j++) begin
            wr_b = (j == 5);
            duty_b = 4'd9;
            step();
        end
        wr_b = 1'b0;
        checks++;
        if (pwm_b !== 3'b101) begin
            errors++; $display("FAIL pre_before_reset: got %b expected 101", pwm_b);
        end
        rst_b = 1'b1;
        step();
        checks++;
        if (pwm_b !== 3'b100 || per_b !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs: got %b/%b expected 100/0", pwm_b, per_b);
        end
        rst_b = 1'b0;
        n = -1;
        for (int k = 1; k <= 200; k++) begin
            step();
            if (per_b === 1'b1) begin n = k; break; end
        end
        checks++;
        if (n != 60) begin
            errors++; $display("FAIL midreset_restart: got %0d expected 60", n);
        end
        measure_b(h0, h2, b20, b21, per_at);
        checks++;
        if (h0 != 0) begin
            errors++; $display("FAIL midreset_pending_dropped: got %0d expected 0", h0);
        end
    endtask

    initial begin
        rst_a = 1'b1; wr_a = 1'b0; ch_a = 2'd0; duty_a = 8'd0;
        rst_b = 1'b1; wr_b = 1'b0; ch_b = 2'd0; duty_b = 4'd0;
        test_reset();
        test_duty();
        test_last_write_wins();
        test_boundary_write();
        test_prescale_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
